// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: fetches one word per instruction from synchronous instruction memory,
// holds it in IR with decoded fields, and advances the PC (optionally branching) on updPC edges.
module instruction_fetch_unit #(
    parameter logic [31:0] NOP_WORD = 32'h94000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        updPC,
    input  logic [2:0]  brOp,
    input  logic [31:0] rsVal,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemData,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  func,
    output logic [31:0] imm,
    output logic [31:0] pc,
    output logic        instrValid,
    output logic        brTaken
);

    typedef enum logic [1:0] {StFetch, StWait, StHold} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] instr_pc_q;
    logic        valid_q;
    logic        br_taken_q;
    logic        upd_prev_q;

    logic        taken;
    logic        upd_edge;
    logic [31:0] branch_off;
    logic [31:0] next_pc;

    always_comb begin
        taken = 1'b0;
        case (brOp)
            3'b001:  taken = 1'b1;
            3'b010:  taken = rsVal[31];
            3'b011:  taken = ~rsVal[31] & (rsVal != 32'd0);
            3'b100:  taken = (rsVal == 32'd0);
            default: taken = 1'b0;
        endcase
    end

    assign upd_edge   = updPC & ~upd_prev_q;
    assign branch_off = {{11{ir_q[20]}}, ir_q[20:0]};
    assign next_pc    = pc_q + 32'd1 + (taken ? branch_off : 32'd0);

    // Edge history tracks updPC in every state so a level held across a refetch cannot retrigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFetch;
            pc_q       <= 32'd0;
            ir_q       <= NOP_WORD;
            instr_pc_q <= 32'd0;
            valid_q    <= 1'b0;
            br_taken_q <= 1'b0;
            upd_prev_q <= 1'b0;
        end else begin
            upd_prev_q <= updPC;
            br_taken_q <= 1'b0;
            case (state_q)
                StFetch: state_q <= StWait;
                StWait: begin
                    ir_q       <= imemData;
                    instr_pc_q <= pc_q;
                    valid_q    <= 1'b1;
                    state_q    <= StHold;
                end
                StHold: begin
                    if (upd_edge) begin
                        pc_q       <= next_pc;
                        valid_q    <= 1'b0;
                        br_taken_q <= taken;
                        state_q    <= StFetch;
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    assign imemAddr   = pc_q;
    assign opcode     = ir_q[31:26];
    assign rs         = ir_q[25:21];
    assign rt         = ir_q[20:16];
    assign rd         = ir_q[15:11];
    assign func       = ir_q[4:0];
    assign imm        = {{16{ir_q[15]}}, ir_q[15:0]};
    assign pc         = instr_pc_q;
    assign instrValid = valid_q;
    assign brTaken    = br_taken_q;

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
- REQ-001 SHALL use a single clock and a synchronous, active-high reset; all state updates on posedge clk.
- REQ-002 SHALL have port: clk  input  1  system clock.
- REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
- REQ-004 SHALL have port: updPC  input  1  PC-update strobe from the control unit, high one cycle at instruction end.
- REQ-005 SHALL have port: brOp  input  3  branch select (000 none, 001 BR, 010 BMI, 011 BPL, 100 BZ, others none).
- REQ-006 SHALL have port: rsVal  input  32  signed register value tested by conditional branches.
- REQ-007 SHALL have port: imemAddr  output  32  instruction-memory word address.
- REQ-008 SHALL have port: imemData  input  32  instruction word, valid one cycle after imemAddr is presented.
- REQ-009 SHALL have port: opcode  output  6  IR[31:26].
- REQ-010 SHALL have port: rs, rt, rd  output  5 each  IR[25:21], IR[20:16], IR[15:11].
- REQ-011 SHALL have port: func  output  5  IR[4:0].
- REQ-012 SHALL have port: imm  output  32  IR[15:0] sign-extended.
- REQ-013 SHALL have port: pc  output  32  address of the instruction in IR.
- REQ-014 SHALL have port: instrValid  output  1  high while IR holds a freshly fetched instruction.
- REQ-015 SHALL have port: brTaken  output  1  one-cycle pulse when a PC update selected the branch target.
- REQ-016 SHALL define parameter NOP_WORD, default 32'h94000000, meaning the IR value loaded on reset.

Function
- REQ-017 SHALL implement FSM states FETCH, WAIT, HOLD.
- REQ-018 In FETCH, SHALL drive imemAddr=PC and go to WAIT next cycle.
- REQ-019 In WAIT, SHALL latch imemData into IR, set pc=PC, and go to HOLD; instrValid rises the cycle after the latch.
- REQ-020 In HOLD, SHALL keep IR, PC and decoded fields stable; instrValid=1.
- REQ-021 In HOLD, SHALL detect a rising edge of updPC (updPC=1 and its previous-cycle value was 0); on detect, load PC with the next address, clear instrValid, and go to FETCH.
- REQ-022 Next address SHALL be PC+1+sext(IR[20:0]) if taken, else PC+1, in modulo-2^32 arithmetic; 32'hFFFFFFFF+1 wraps to 0.
- REQ-023 Taken SHALL mean: BR always; BMI if rsVal[31]=1; BPL if rsVal[31]=0 and rsVal!=0; BZ if rsVal==0; none/reserved never.
- REQ-024 brOp and rsVal SHALL be sampled in the same cycle updPC edge is detected.
- REQ-025 brTaken SHALL pulse high exactly in the cycle after a taken update, else 0.
- REQ-026 updPC held high for multiple cycles SHALL cause exactly one update.
- REQ-027 updPC asserted in FETCH or WAIT SHALL be ignored; its edge history still updates.
- REQ-028 Total latency from updPC edge to instrValid=1 SHALL be 3 cycles.
- REQ-029 With no updPC edge (e.g. control unit in HALT), HOLD SHALL persist indefinitely.

Reset
- REQ-030 On rst=1 at a clock edge: PC=0, pc=0, IR=NOP_WORD, instrValid=0, brTaken=0, updPC edge history=0, state=FETCH; the cycle after reset release fetches address 0.
- REQ-031 Reset SHALL override every other input in any state, including mid-fetch and in the same cycle as an updPC edge.

Verification
- REQ-032 Reset release, imem[0]=32'h04221005 -> imemAddr=0, then opcode=6'h01, rs=1, rt=2, imm=32'h00001005, pc=0, instrValid=1 within 3 cycles.
- REQ-033 HOLD at PC=5, brOp=000, updPC pulse -> next fetch at 6, brTaken=0, instrValid low 2 cycles then high.
- REQ-034 PC=10, IR[20:0]=21'h1FFFFC (-4), brOp=100, rsVal=0, updPC pulse -> next fetch at 7, brTaken=1 for 1 cycle; repeat with rsVal=1 -> 11, brTaken=0.
- REQ-035 BMI/BPL with rsVal=32'h80000000, 0, 5 -> taken only for BMI/80000000 and BPL/5.
- REQ-036 PC=32'hFFFFFFFF, brOp=000, updPC held 4 cycles -> single update to 0, one refetch only.
- REQ-037 rst asserted in WAIT -> PC=0, IR=NOP_WORD, instrValid=0, refetch from 0 after release.
